// File: rtl/counterdown_pkg.sv
// Shared widths and FSM encoding for the segmented 36-bit down counter.
// No logic; no latency or backpressure.
package counterdown_pkg;

  localparam int SEG0_W = 8;
  localparam int SEG1_W = 12;
  localparam int SEG2_W = 16;
  localparam int CNT_W  = SEG0_W + SEG1_W + SEG2_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counterdown_seg.sv
// Loadable down-counting segment; wraps 0 -> all-ones when told to decrement at zero.
// One-cycle update from load/dec; no backpressure, load beats dec.
module counterdown_seg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - W'(1);
    end
  end

  assign is_zero = (value == '0);

endmodule

// File: rtl/counterdown36_1clk_async_resetn.sv
// 36-bit segmented down counter with IDLE/RUN/DONE FSM; COUNTERDOWN_AUTORELOAD_EN reloads from DONE.
// Count and done update one cycle after load/enable; no backpressure, load always wins over enable.
module counterdown36_1clk_async_resetn
  import counterdown_pkg::*;
#(
  parameter int W0 = SEG0_W,
  parameter int W1 = SEG1_W,
  parameter int W2 = SEG2_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [W0+W1+W2-1:0] load_value,
  input  logic                enable,
  output logic [W0+W1+W2-1:0] count,
  output logic                zero,
  output logic                busy,
  output logic                done
);

  localparam int N = W0 + W1 + W2;

`ifdef COUNTERDOWN_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   reload;
  logic [N-1:0]   seg_value;
  logic           seg_load;
  logic           run_dec;
  logic           count_is_one;
  logic [W0-1:0]  v0;
  logic [W1-1:0]  v1;
  logic [W2-1:0]  v2;
  logic           z0;
  logic           z1;
  logic           z2;

  assign count_is_one = (count == N'(1));
  assign run_dec      = (state == ST_RUN) && enable && !load;
  // Auto-reload reuses the segment load path with the captured start value.
  assign seg_load     = load || (AUTORELOAD && (state == ST_DONE));
  assign seg_value    = load ? load_value : reload;

  counterdown_seg #(.W(W0)) u_seg0 (
    .clk(clk), .reset(reset), .load(seg_load), .load_value(seg_value[W0-1:0]),
    .dec(run_dec), .value(v0), .is_zero(z0)
  );

  counterdown_seg #(.W(W1)) u_seg1 (
    .clk(clk), .reset(reset), .load(seg_load), .load_value(seg_value[W0+W1-1:W0]),
    .dec(run_dec && z0), .value(v1), .is_zero(z1)
  );

  counterdown_seg #(.W(W2)) u_seg2 (
    .clk(clk), .reset(reset), .load(seg_load), .load_value(seg_value[N-1:W0+W1]),
    .dec(run_dec && z0 && z1), .value(v2), .is_zero(z2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= run_dec && count_is_one;
      if (load && (load_value != '0)) begin
        reload <= load_value;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN:  if (enable && count_is_one) state_nxt = ST_DONE;
        ST_DONE: state_nxt = AUTORELOAD ? ST_RUN : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == ST_RUN);
    zero  = z0 && z1 && z2;
    count = {v2, v1, v0};
  end

endmodule

// File: tb/tb_counterdown36_1clk_async_resetn.sv
// Directed bench for the segmented down counter; expected values are hand-computed.
// Build with or without COUNTERDOWN_AUTORELOAD_EN; expectations follow the macro.
module tb_counterdown36_1clk_async_resetn;

  logic        clk;
  logic        reset;
  logic        load;
  logic [35:0] load_value;
  logic        enable;
  logic [35:0] count;
  logic        zero;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  counterdown36_1clk_async_resetn dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count(count), .zero(zero), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [35:0] v, input logic en);
    load       = 1'b1;
    load_value = v;
    enable     = en;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load = 1'b0; load_value = '0; enable = 1'b0;
    #2 reset = 1'b0;
    #2;
    total++; if (count !== 36'd0) begin bad++; $display("FAIL reset_count got=%h exp=%h", count, 36'd0); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    tick(); tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_load(36'h000000123, 1'b0);
    total++; if (count !== 36'h000000123) begin bad++; $display("FAIL midrun_loaded got=%h exp=%h", count, 36'h000000123); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    #2 reset = 1'b0;
    #1;
    total++; if (count !== 36'd0) begin bad++; $display("FAIL midrun_async_clear got=%h exp=%h", count, 36'd0); end
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    tick(); tick(); tick();
    total++; if (count !== 36'd0) begin bad++; $display("FAIL midrun_after_count got=%h exp=%h", count, 36'd0); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL midrun_after_zero got=%b exp=1", zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_after_busy got=%b exp=0", busy); end
    enable = 1'b0;
  endtask

  task automatic test_countdown();
    logic [35:0] exp_c [6] = '{36'd5, 36'd4, 36'd3, 36'd2, 36'd1, 36'd0};
    logic        exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    load = 1'b1; load_value = 36'd5; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0;
      total++; if (count !== exp_c[i]) begin bad++; $display("FAIL countdown_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
      total++; if (done !== exp_d[i]) begin bad++; $display("FAIL countdown_done[%0d] got=%b exp=%b", i, done, exp_d[i]); end
      total++; if (busy !== exp_b[i]) begin bad++; $display("FAIL countdown_busy[%0d] got=%b exp=%b", i, busy, exp_b[i]); end
    end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL countdown_zero got=%b exp=1", zero); end
    do_load(36'd0, 1'b1);
    total++; if (count !== 36'd0) begin bad++; $display("FAIL load_zero_count got=%h exp=0", count); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL load_zero_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_zero_busy got=%b exp=0", busy); end
  endtask

  task automatic test_borrow();
    do_load(36'h000000100, 1'b0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++; if (count !== 36'h0000000FF) begin bad++; $display("FAIL borrow_seg1 got=%h exp=%h", count, 36'h0000000FF); end
    tick();
    total++; if (count !== 36'h0000000FF) begin bad++; $display("FAIL hold_disabled got=%h exp=%h", count, 36'h0000000FF); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
    do_load(36'h000100000, 1'b0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++; if (count !== 36'h0000FFFFF) begin bad++; $display("FAIL borrow_seg2 got=%h exp=%h", count, 36'h0000FFFFF); end
  endtask

  task automatic test_load_priority();
    do_load(36'd7, 1'b0);
    total++; if (count !== 36'd7) begin bad++; $display("FAIL prio_setup got=%0d exp=7", count); end
    do_load(36'd3, 1'b1);
    total++; if (count !== 36'd3) begin bad++; $display("FAIL prio_load got=%0d exp=3", count); end
    tick();
    total++; if (count !== 36'd2) begin bad++; $display("FAIL prio_next got=%0d exp=2", count); end
    enable = 1'b0;
  endtask

  task automatic test_autoreload();
`ifdef COUNTERDOWN_AUTORELOAD_EN
    logic [35:0] exp_c [6] = '{36'd2, 36'd1, 36'd0, 36'd2, 36'd1, 36'd0};
    logic        exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic [35:0] exp_c [6] = '{36'd2, 36'd1, 36'd0, 36'd0, 36'd0, 36'd0};
    logic        exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    load = 1'b1; load_value = 36'd2; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0;
      total++; if (count !== exp_c[i]) begin bad++; $display("FAIL reload_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
      total++; if (done !== exp_d[i]) begin bad++; $display("FAIL reload_done[%0d] got=%b exp=%b", i, done, exp_d[i]); end
    end
    do_load(36'd0, 1'b0);
  endtask

  task automatic test_idle_ignore();
    enable = 1'b1;
    tick(); tick();
    total++; if (count !== 36'd0) begin bad++; $display("FAIL idle_count got=%h exp=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b exp=0", done); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_countdown();
    test_borrow();
    test_load_priority();
    test_autoreload();
    test_idle_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counterdown36_1clk_async_resetn.md
COUNTERDOWN36_1CLK_ASYNC_RESETN -- requirements
Module: counterdown36_1clk_async_resetn

Interface
REQ-001 SHALL have parameter W0, default 8: width of segment 0, count[7:0].
REQ-002 SHALL have parameter W1, default 12: width of segment 1, count[19:8].
REQ-003 SHALL have parameter W2, default 16: width of segment 2, count[35:20]; N = W0+W1+W2 = 36.
REQ-004 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  capture load_value into count and reload register.
REQ-007 SHALL have port load_value  input  36  start value.
REQ-008 SHALL have port enable  input  1  permits one decrement per cycle in RUN.
REQ-009 SHALL have port count  output  36  current counter value (registered).
REQ-010 SHALL have port zero  output  1  high when count == 0 (decoded from the count register).
REQ-011 SHALL have port busy  output  1  high when the FSM is in RUN.
REQ-012 SHALL have port done  output  1  registered one-cycle pulse when the count reaches 0 from RUN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL give load priority over enable in every state.
REQ-015 On load with load_value != 0: next count = load_value, reload register = load_value, state -> RUN.
REQ-016 On load with load_value == 0: next count = 0, state -> IDLE, no done pulse.
REQ-017 In RUN with enable=1 and no load: count decrements by exactly 1.
REQ-018 In RUN with enable=0: count and state hold.
REQ-019 Decrement SHALL be segmented: seg0 decrements every enabled cycle; seg1 decrements only when seg0 == 0; seg2 decrements only when seg0 == 0 and seg1 == 0.
REQ-020 A decrementing segment at 0 SHALL wrap to all-ones (0xFF, 0xFFF, 0xFFFF).
REQ-021 In RUN with enable=1 and count == 1: next count = 0, state -> DONE, done = 1 in that same next cycle.
REQ-022 done SHALL be high for exactly one cycle per terminal event.
REQ-023 In IDLE without load: count holds and enable is ignored.
REQ-024 busy SHALL be 0 in IDLE and DONE and 1 in RUN.

Reset
REQ-025 When reset is low: count = 0, reload register = 0, zero = 1, busy = 0, done = 0, state = IDLE, asynchronously.
REQ-026 Reset asserted mid-RUN SHALL abort the count; after release the block SHALL stay in IDLE until load.

Configuration
REQ-027 Macro COUNTERDOWN_AUTORELOAD_EN SHALL select the exit from DONE.
REQ-028 With the macro defined: DONE -> RUN and count = reload register on the next cycle, giving a period of reload+1 cycles with enable held high.
REQ-029 Without the macro: DONE -> IDLE and count stays 0 until the next load.

Structure
REQ-030 Package counterdown_pkg SHALL hold the segment-width constants (8, 12, 16), total width 36, and the FSM state enumeration.
REQ-031 A sub-module counterdown_seg SHALL implement a parameterised-width loadable down segment with decrement-enable input and is-zero output; the top level SHALL instantiate it three times and own the FSM.

Verification
REQ-032 Reset low mid-RUN with count = 0x000000123, then release -> count = 0, zero = 1, busy = 0, stays in IDLE.
REQ-033 Load 5, enable held high -> count 5,4,3,2,1,0; done pulses once on the cycle count = 0; busy falls in the same cycle.
REQ-034 Load 0x000000100, one enabled cycle -> count = 0x0000000FF (seg0 wraps, seg1 borrows).
REQ-035 Load 0x000100000, one enabled cycle -> count = 0x0000FFFFF (seg0 and seg1 wrap, seg2 borrows).
REQ-036 load and enable both high in RUN at count = 7, load_value = 3 -> count = 3, no decrement that cycle.
REQ-037 Load 2, enable high, with COUNTERDOWN_AUTORELOAD_EN -> sequence 2,1,0,2,1,0, done every third cycle; without the macro -> 2,1,0,0, done once.
